// File: rtl/serial_adder_seq_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and the held sum/carry-out back.
interface serial_adder_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: one sum1bcc full adder is fed one bit pair per
// clock, LSB first, through a registered carry loop; result held until next start.

module sum1bcc (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic out,
  output logic z
);
  assign out = x ^ y ^ c;
  assign z   = (x & y) | (c & (x ^ y));
endmodule

module serial_adder_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_seq_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_out, fa_z;
  logic             last_c;
  logic [WIDTH-1:0] res_next_c;

  sum1bcc u_fa (
    .x   (a_sh_q[0]),
    .y   (b_sh_q[0]),
    .c   (carry_q),
    .out (fa_out),
    .z   (fa_z)
  );

  assign last_c = (cnt_q == CW'(WIDTH - 1));
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign res_next_c = WIDTH'({fa_out, res_sh_q} >> 1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_SHIFT;
      S_SHIFT: if (last_c)    state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Status outputs, registered so they line up with the state they describe
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_SHIFT) busy_d = 1'b1;
    if (state_d == S_DONE)  done_d = 1'b1;
  end

  // Datapath next values; everything holds outside IDLE-load and SHIFT
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          carry_d  = bus.cin;
          res_sh_d = '0;
          cnt_d    = '0;
        end
      end
      S_SHIFT: begin
        res_sh_d = res_next_c;
        carry_d  = fa_z;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_c) begin
          sum_d  = res_next_c;
          cout_d = fa_z;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: doc/serial_adder_seq.md
Name: serial_adder_seq

Overview:
Bit-serial N-bit adder built around the team's 1-bit full adder sum1bcc. Port order: x, y, c, out (sum), z (carry-out).
- Loads two N-bit operands and a carry-in on a start request.
- Feeds sum1bcc one bit pair per clock, LSB first, with a registered carry loop.
- Assembles the N-bit sum and reports it with a one-cycle done pulse.
- Sits directly upstream of sum1bcc as its sequencer and operand feeder; replaces a parallel ripple chain where area matters more than latency.

Parameters:
WIDTH, 4, operand and sum width in bits (legal range 1..32).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to begin an addition; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on an accepted start.
- b  in  WIDTH  operand B; captured on an accepted start.
- cin  in  1  carry-in; captured on an accepted start.
- busy  out  1  high while bits are being processed (SHIFT state).
- done  out  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  out  WIDTH  result a+b+cin mod 2^WIDTH; held until the next accepted start.
- cout  out  1  carry-out of the MSB; held like sum.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry register and bit counter cleared.
  - Takes effect immediately, including mid-operation. No partial result survives.
- Single sum1bcc instance:
  - x = a_sh[0], y = b_sh[0], c = carry_q.
  - out is the sum bit, z is the next carry.
- States:
  - IDLE
    - start=1 → load a_sh<=a, b_sh<=b, carry_q<=cin, res_sh<=0, cnt<=0; go to SHIFT.
    - start=0 → stay. Outputs sum/cout retain their last values.
  - SHIFT (busy=1), every edge:
    - res_sh <= {fa_out, res_sh[WIDTH-1:1]}.
    - carry_q <= fa_z.
    - a_sh, b_sh shift right by one with 0 fill.
    - cnt <= cnt+1.
    - When cnt == WIDTH-1 on this edge: sum <= {fa_out, res_sh[WIDTH-1:1]}, cout <= fa_z, done <= 1; go to DONE.
  - DONE (busy=0, done=1 for exactly this cycle): next edge → IDLE, done <= 0.
- Latency:
  - start sampled at edge E0.
  - busy high for exactly WIDTH cycles (E0..E(WIDTH)).
  - done high in the cycle after edge E(WIDTH).
  - sum/cout update on that same edge.
  - Next start accepted at edge E(WIDTH+2) at the earliest: WIDTH+2 cycles per operation.
- start while busy or in DONE: ignored. No queueing, no effect on the operation in flight or on the result.
- Operand inputs a/b/cin may change freely after the start edge; only the captured values are used.
- WIDTH=1: a single SHIFT cycle; result equals sum1bcc's truth table directly.
- cnt width: clog2(WIDTH)+1 bits; no wrap within an operation.
- Counter and shift registers hold in IDLE and DONE.
- busy and done are never high simultaneously. done never stays high for more than one cycle.

Test Plan:
- WIDTH=4, a=5, b=3, cin=0, start pulse → busy high 4 cycles; done pulse next cycle; sum=8, cout=0.
- WIDTH=4:
  - a=15, b=1, cin=0 → sum=0, cout=1.
  - then a=15, b=15, cin=1 → sum=15, cout=1.
  - sum/cout hold between operations.
- WIDTH=4, start held high continuously with a=2, b=2 → operations accepted every 6 cycles. a/b changed to 7,7 during busy has no effect until the next accept; first result sum=4, cout=0.
- WIDTH=4, rst_n pulsed low 2 cycles after start (a=9, b=9) → busy, done, sum, cout go to 0 immediately, with no clock edge required. Following a=9, b=9 operation gives sum=2, cout=1.
- WIDTH=1, all 8 combinations of a, b, cin → sum and cout match the full-adder truth table: {000→0,0; 001→1,0; 010→1,0; 011→0,1; 100→1,0; 101→0,1; 110→0,1; 111→1,1}.
- WIDTH=8, random self-checking against a+b+cin, 200 operations → zero mismatches. done count equals accepted start count.
